// File: rtl/clkgen_pkg.sv
// Shared types for the clkgen_div clock/strobe generator.
package clkgen_pkg;

  // Default counter width; channels carry their own CNT_W parameter.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } chan_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } chan_cfg_t;

endpackage

// File: rtl/clkgen_chan.sv
// One clkgen channel: run/stop FSM, period counter, shadow and active config,
// registered clk/tick outputs. Config changes only take effect at a period start.
module clkgen_chan #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             sync_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] high_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o
);
  import clkgen_pkg::*;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } cfg_t;

  chan_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  cfg_t             shadow_q;
  cfg_t             active_q;
  logic             clk_q;
  logic             tick_q;

  cfg_t             cfg_new;
  logic [CNT_W:0]   cnt_inc;
  logic             at_end;
  logic             restart;

  // Config seen by a period start this cycle (a coincident load bypasses the shadow),
  // widened increment for the high-time compare, and wrap/restart decode.
  always_comb begin
    cfg_new = shadow_q;
    if (load_i) begin
      cfg_new.period = period_i;
      cfg_new.high   = high_i;
    end
    cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    at_end  = (cnt_q == active_q.period);
    // sync wins over a wrap; a wrap with en low ends the channel instead
    restart = sync_i || (at_end && en_i);
  end

  // Channel FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_q <= cfg_new;
      end
      case (state_q)
        IDLE: begin
          if (en_i) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            active_q <= cfg_new;
            tick_q   <= 1'b1;
            clk_q    <= (cfg_new.high != '0);
          end else begin
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
          end
        end
        RUN, STOP: begin
          if (restart) begin
            // STOP with en high resumes without a gap; STOP under sync keeps stopping
            state_q  <= en_i ? RUN : STOP;
            cnt_q    <= '0;
            active_q <= cfg_new;
            tick_q   <= 1'b1;
            clk_q    <= (cfg_new.high != '0);
          end else if (at_end) begin
            // Period completed with en low: finish cleanly, no new tick
            state_q <= IDLE;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
          end else begin
            state_q <= en_i ? RUN : STOP;
            cnt_q   <= cnt_inc[CNT_W-1:0];
            tick_q  <= 1'b0;
            clk_q   <= (cnt_inc < {1'b0, active_q.high});
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          clk_q   <= 1'b0;
          tick_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/clkgen_div.sv
// Multi-channel clock/strobe generator top: unpacks per-channel config buses and
// fans load/sync out to NUM_CH clkgen_chan instances.
// Optional feature: define CLKGEN_SYNC_EN to add sync_i, a phase restart of all
// running/stopping channels.
module clkgen_div #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic                    load_i,
  input  logic [NUM_CH*CNT_W-1:0] period_i,
  input  logic [NUM_CH*CNT_W-1:0] high_i,
`ifdef CLKGEN_SYNC_EN
  input  logic                    sync_i,
`endif
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       busy_o
);
  import clkgen_pkg::*;

  logic sync_all;

`ifdef CLKGEN_SYNC_EN
  assign sync_all = sync_i;
`else
  assign sync_all = 1'b0;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    clkgen_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en_i[k]),
      .load_i  (load_i),
      .sync_i  (sync_all),
      .period_i(period_i[k*CNT_W +: CNT_W]),
      .high_i  (high_i[k*CNT_W +: CNT_W]),
      .clk_o   (clk_o[k]),
      .tick_o  (tick_o[k]),
      .busy_o  (busy_o[k])
    );
  end

endmodule

// File: tb/tb_clkgen_div.sv
// Self-checking bench for clkgen_div: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a phase-based channel model.
module tb_clkgen_div;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       en_i;
  logic                    load_i;
  logic [NUM_CH*CNT_W-1:0] period_i;
  logic [NUM_CH*CNT_W-1:0] high_i;
`ifdef CLKGEN_SYNC_EN
  logic                    sync_i;
`endif
  logic [NUM_CH-1:0]       clk_o;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       busy_o;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_on      = 0;

  clkgen_div #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en_i),
    .load_i  (load_i),
    .period_i(period_i),
    .high_i  (high_i),
`ifdef CLKGEN_SYNC_EN
    .sync_i  (sync_i),
`endif
    .clk_o   (clk_o),
    .tick_o  (tick_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [NUM_CH-1:0] act,
                      input logic [NUM_CH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a running channel sits at some phase 0..P of its period; outputs follow
  // directly from that phase (high while phase < H, tick at phase 0).
  bit m_act [NUM_CH];
  int m_ph  [NUM_CH];
  int m_p   [NUM_CH];
  int m_h   [NUM_CH];
  int m_sp  [NUM_CH];
  int m_sh  [NUM_CH];

  initial begin
    for (int k = 0; k < NUM_CH; k++) begin
      m_act[k] = 0; m_ph[k] = 0; m_p[k] = 0; m_h[k] = 0; m_sp[k] = 0; m_sh[k] = 0;
    end
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_act[k] = 0; m_ph[k] = 0; m_p[k] = 0; m_h[k] = 0; m_sp[k] = 0; m_sh[k] = 0;
      end
    end else begin
      bit sy;
      sy = 0;
`ifdef CLKGEN_SYNC_EN
      sy = sync_i;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        int np;
        int nh;
        np = load_i ? int'(period_i[k*CNT_W +: CNT_W]) : m_sp[k];
        nh = load_i ? int'(high_i[k*CNT_W +: CNT_W]) : m_sh[k];
        if (load_i) begin
          m_sp[k] = np;
          m_sh[k] = nh;
        end
        if (!m_act[k]) begin
          if (en_i[k]) begin
            m_act[k] = 1; m_ph[k] = 0; m_p[k] = np; m_h[k] = nh;
          end
        end else if (sy || (m_ph[k] == m_p[k] && en_i[k])) begin
          m_ph[k] = 0; m_p[k] = np; m_h[k] = nh;
        end else if (m_ph[k] == m_p[k]) begin
          m_act[k] = 0;
          m_ph[k]  = 0;
        end else begin
          m_ph[k] = m_ph[k] + 1;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      logic [NUM_CH-1:0] ec;
      logic [NUM_CH-1:0] et;
      logic [NUM_CH-1:0] eb;
      for (int k = 0; k < NUM_CH; k++) begin
        eb[k] = m_act[k];
        ec[k] = m_act[k] && (m_ph[k] < m_h[k]);
        et[k] = m_act[k] && (m_ph[k] == 0);
      end
      chkv("model_clk", clk_o, ec);
      chkv("model_tick", tick_o, et);
      chkv("model_busy", busy_o, eb);
    end
  end

  task automatic cfg(input int ch, input int p, input int h);
    period_i[ch*CNT_W +: CNT_W] = CNT_W'(p);
    high_i[ch*CNT_W +: CNT_W]   = CNT_W'(h);
  endtask

  task automatic pulse_load();
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chkv({tag, "_clk"}, clk_o, '0);
    chkv({tag, "_tick"}, tick_o, '0);
    chkv({tag, "_busy"}, busy_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b1;
    en_i     = '0;
    load_i   = 1'b0;
    period_i = '0;
    high_i   = '0;
`ifdef CLKGEN_SYNC_EN
    sync_i   = 1'b0;
`endif
    #1 rst_n = 1'b0;
    step(2);
    chkv("rst_clk", clk_o, '0);
    chkv("rst_tick", tick_o, '0);
    chkv("rst_busy", busy_o, '0);
    rst_n  = 1'b1;
    cmp_on = 1;
    step(1);

    // Reset mid-run clears outputs before any clock edge
    cfg(0, 3, 2);
    cfg(1, 3, 2);
    pulse_load();
    en_i = 2'b11;
    step(3);
    en_i = 2'b00;
    async_reset_check("t1_async");
    step(1);

    // Divide-by-4, 50%
    cfg(0, 3, 2);
    pulse_load();
    en_i[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("t2_clk", clk_o[0], (i % 4) < 2);
      chk1("t2_tick", tick_o[0], (i % 4) == 0);
      chk1("t2_busy", busy_o[0], 1'b1);
    end
    en_i[0] = 1'b0;
    step(1);
    chk1("t2_stop_busy", busy_o[0], 1'b0);

    // 30% duty, then a mid-period reload that waits for the next period
    cfg(0, 9, 3);
    pulse_load();
    en_i[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("t3_clk", clk_o[0], i < 3);
      chk1("t3_tick", tick_o[0], i == 0);
    end
    cfg(0, 4, 1);
    pulse_load();
    chk1("t3_hold_clk", clk_o[0], 1'b0);
    chk1("t3_hold_tick", tick_o[0], 1'b0);
    for (int i = 6; i < 10; i++) begin
      @(negedge clk);
      chk1("t3_old_clk", clk_o[0], 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("t3_new_clk", clk_o[0], (i % 5) == 0);
      chk1("t3_new_tick", tick_o[0], (i % 5) == 0);
    end
    en_i[0] = 1'b0;
    step(6);

    // Graceful stop, then re-enable while stopping
    cfg(1, 7, 4);
    pulse_load();
    en_i[1] = 1'b1;
    step(2);
    en_i[1] = 1'b0;
    for (int j = 2; j < 8; j++) begin
      @(negedge clk);
      chk1("t4_stop_busy", busy_o[1], 1'b1);
      chk1("t4_stop_clk", clk_o[1], j < 4);
      chk1("t4_stop_tick", tick_o[1], 1'b0);
    end
    @(negedge clk);
    chk1("t4_idle_busy", busy_o[1], 1'b0);
    chk1("t4_idle_clk", clk_o[1], 1'b0);
    chk1("t4_idle_tick", tick_o[1], 1'b0);
    en_i[1] = 1'b1;
    step(4);
    en_i[1] = 1'b0;
    step(2);
    en_i[1] = 1'b1;
    step(2);
    @(negedge clk);
    chk1("t4_cont_tick", tick_o[1], 1'b1);
    chk1("t4_cont_busy", busy_o[1], 1'b1);
    en_i[1] = 1'b0;
    step(9);

    // Edge configurations
    cfg(0, 2, 0);
    cfg(1, 5, 12);
    pulse_load();
    en_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("t5_h0_clk", clk_o[0], 1'b0);
      chk1("t5_hbig_clk", clk_o[1], 1'b1);
    end
    en_i = 2'b00;
    step(7);
    cfg(0, 0, 1);
    pulse_load();
    en_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t5_p0_tick", tick_o[0], 1'b1);
      chk1("t5_p0_clk", clk_o[0], 1'b1);
    end
    en_i[0] = 1'b0;
    step(2);
    chkv("t5_idle_busy", busy_o, '0);

`ifdef CLKGEN_SYNC_EN
    // Phase alignment of two channels started two cycles apart
    cfg(0, 3, 2);
    cfg(1, 5, 3);
    pulse_load();
    en_i[0] = 1'b1;
    step(2);
    en_i[1] = 1'b1;
    step(3);
    sync_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0;
    chkv("t6_sync_tick", tick_o, 2'b11);
    chkv("t6_sync_clk0", clk_o, 2'b11);
    step(1);
    chkv("t6_sync_clk1", clk_o, 2'b11);
    step(1);
    chkv("t6_sync_clk2", clk_o, 2'b10);
    en_i = 2'b00;
    step(8);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) begin
        int p;
        int h;
        if ($urandom_range(9) == 0) en_i[k] = ~en_i[k];
        p = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(6));
        h = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(p + 2));
        cfg(k, p, h);
      end
      load_i = ($urandom_range(5) == 0);
`ifdef CLKGEN_SYNC_EN
      sync_i = ($urandom_range(19) == 0);
`endif
      if ($urandom_range(999) == 0) begin
        async_reset_check("rnd_async");
      end
    end
    @(negedge clk);
    load_i = 1'b0;
    en_i   = '0;
`ifdef CLKGEN_SYNC_EN
    sync_i = 1'b0;
`endif
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
